// File: rtl/pipeline_controller_if.sv
// Bundle between the IF/ID-EX pipeline glue and the main decoder: ID-stage
// inputs, hazard/branch inputs and the registered ID/EX control outputs.
interface pipeline_controller_if #(
    parameter int REG_W = 5
);
    logic [31:0]      Instruction;
    logic             IdValid;
    logic             ExMemRead;
    logic [REG_W-1:0] ExRt;
    logic             BranchTaken;

    logic [1:0]       RegDst;
    logic [3:0]       ALUOp;
    logic [1:0]       ALUSrc;
    logic             Branch;
    logic [2:0]       BranchCond;
    logic             MemRead;
    logic             MemWrite;
    logic [1:0]       MemSize;
    logic             MemtoReg;
    logic             RegWrite;
    logic             Jump;
    logic             JumpReg;
    logic             Link;
    logic             ExValid;
    logic             Stall;
    logic             FlushIF;
    logic             Debug;
    logic [5:0]       DebugOpcode;

    // No handshake: the decoder samples its inputs on every rising edge, and
    // Stall/FlushIF tell the pipeline glue what to do with PC and IF/ID.
    modport master (
        output Instruction, IdValid, ExMemRead, ExRt, BranchTaken,
        input  RegDst, ALUOp, ALUSrc, Branch, BranchCond, MemRead, MemWrite,
               MemSize, MemtoReg, RegWrite, Jump, JumpReg, Link, ExValid,
               Stall, FlushIF, Debug, DebugOpcode
    );

    modport slave (
        input  Instruction, IdValid, ExMemRead, ExRt, BranchTaken,
        output RegDst, ALUOp, ALUSrc, Branch, BranchCond, MemRead, MemWrite,
               MemSize, MemtoReg, RegWrite, Jump, JumpReg, Link, ExValid,
               Stall, FlushIF, Debug, DebugOpcode
    );
endinterface

// File: rtl/pipeline_controller.sv
// Registered MIPS main decoder: ID -> ID/EX control bundle, load-use stall,
// taken-branch squash counter and a sticky illegal-opcode debug capture.
module pipeline_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_W        = 5
) (
    input logic                  Clk,
    input logic                  Rst_n,
    pipeline_controller_if.slave bus
);
    typedef struct packed {
        logic [1:0] reg_dst;
        logic [3:0] alu_op;
        logic [1:0] alu_src;
        logic       branch;
        logic [2:0] branch_cond;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_to_reg;
        logic       reg_write;
        logic       jump;
        logic       jump_reg;
        logic       link;
        logic       ex_valid;
    } ctrl_t;

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             unused_ok;

    assign opcode    = bus.Instruction[31:26];
    assign funct     = bus.Instruction[5:0];
    assign rs        = REG_W'(bus.Instruction[25:21]);
    assign rt        = REG_W'(bus.Instruction[20:16]);
    assign unused_ok = ^bus.Instruction[15:6];

    ctrl_t dec;
    logic  legal;
    logic  reads_rs;
    logic  reads_rt;

    always_comb begin
        dec      = '0;
        legal    = 1'b1;
        reads_rs = 1'b1;
        reads_rt = 1'b0;
        case (opcode)
            6'b000000: begin
                dec.reg_dst   = 2'd1;
                dec.reg_write = 1'b1;
                reads_rt      = 1'b1;
                if (funct == 6'b001000) begin
                    dec.jump_reg  = 1'b1;
                    dec.reg_write = 1'b0;
                end
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: begin
                dec.alu_src   = 2'd1;
                dec.reg_write = 1'b1;
                case (opcode)
                    6'b001000: dec.alu_op = 4'b0001;
                    6'b001100: dec.alu_op = 4'b0010;
                    6'b001101: dec.alu_op = 4'b0011;
                    6'b001110: dec.alu_op = 4'b0100;
                    default:   dec.alu_op = 4'b0101;
                endcase
            end
            6'b100011, 6'b100001, 6'b100000: begin
                dec.alu_op     = 4'b0001;
                dec.alu_src    = 2'd1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_size   = (opcode == 6'b100011) ? 2'b10 :
                                 (opcode == 6'b100001) ? 2'b01 : 2'b00;
            end
            6'b101011, 6'b101001, 6'b101000: begin
                dec.alu_op    = 4'b0001;
                dec.alu_src   = 2'd1;
                dec.mem_write = 1'b1;
                reads_rt      = 1'b1;
                dec.mem_size  = (opcode == 6'b101011) ? 2'b10 :
                                (opcode == 6'b101001) ? 2'b01 : 2'b00;
            end
            6'b000100, 6'b000101: begin
                dec.alu_op      = 4'b0110;
                dec.branch      = 1'b1;
                dec.branch_cond = (opcode == 6'b000100) ? 3'b000 : 3'b001;
                reads_rt        = 1'b1;
            end
            6'b000110, 6'b000111, 6'b000001: begin
                // Compare-against-zero branches take the zero operand on ALU B
                dec.alu_op  = 4'b0110;
                dec.branch  = 1'b1;
                dec.alu_src = 2'd2;
                case (opcode)
                    6'b000110: dec.branch_cond = 3'b010;
                    6'b000111: dec.branch_cond = 3'b011;
                    default:   dec.branch_cond = bus.Instruction[16] ? 3'b100 : 3'b101;
                endcase
            end
            6'b000010: begin
                dec.jump = 1'b1;
                reads_rs = 1'b0;
            end
            6'b000011: begin
                dec.jump      = 1'b1;
                dec.link      = 1'b1;
                dec.reg_dst   = 2'd2;
                dec.reg_write = 1'b1;
                reads_rs      = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        dec.ex_valid = legal;
    end

    ctrl_t      ctrl_q, ctrl_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;
    logic       debug_q, debug_d;
    logic [5:0] debug_op_q, debug_op_d;
    logic       squash;
    logic       hazard;
    logic       stall;
    logic       debug_hit;

    assign squash = bus.BranchTaken | (flush_cnt_q != 2'd0);
    assign hazard = bus.IdValid & bus.ExMemRead & (bus.ExRt != '0) &
                    ((reads_rs & (bus.ExRt == rs)) | (reads_rt & (bus.ExRt == rt)));
    assign stall  = hazard & ~squash;

    assign debug_hit = bus.IdValid & ~legal & ~squash & ~stall;

    always_comb begin
        if (squash || stall || !bus.IdValid || !legal) ctrl_d = '0;
        else                                           ctrl_d = dec;

        if (bus.BranchTaken)           flush_cnt_d = FLUSH_RELOAD;
        else if (flush_cnt_q != 2'd0)  flush_cnt_d = flush_cnt_q - 2'd1;
        else                           flush_cnt_d = flush_cnt_q;

        // Only the first qualifying illegal opcode is kept until reset
        debug_d    = debug_q | debug_hit;
        debug_op_d = (debug_hit && !debug_q) ? opcode : debug_op_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ctrl_q      <= '0;
            flush_cnt_q <= 2'd0;
            debug_q     <= 1'b0;
            debug_op_q  <= 6'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            flush_cnt_q <= flush_cnt_d;
            debug_q     <= debug_d;
            debug_op_q  <= debug_op_d;
        end
    end

    assign bus.Stall   = stall;
    assign bus.FlushIF = bus.BranchTaken |
                         (bus.IdValid & legal & (dec.jump | dec.jump_reg) & ~stall &
                          (flush_cnt_q == 2'd0));

    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.ALUSrc      = ctrl_q.alu_src;
    assign bus.Branch      = ctrl_q.branch;
    assign bus.BranchCond  = ctrl_q.branch_cond;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.MemSize     = ctrl_q.mem_size;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.Jump        = ctrl_q.jump;
    assign bus.JumpReg     = ctrl_q.jump_reg;
    assign bus.Link        = ctrl_q.link;
    assign bus.ExValid     = ctrl_q.ex_valid;
    assign bus.Debug       = debug_q;
    assign bus.DebugOpcode = debug_op_q;
endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: the driver pushes hand-computed
// ID/EX bundles into a queue, the monitor pops and compares after each edge.
module tb_pipeline_controller;
    logic clk;
    logic rst_n;

    pipeline_controller_if #(.REG_W(5)) bus ();

    pipeline_controller #(.FLUSH_CYCLES(2), .REG_W(5)) dut (
        .Clk  (clk),
        .Rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [28:0] exp_q[$];
    string       name_q[$];
    logic        exp_dbg;
    logic [5:0]  exp_dbg_op;

    // reg_dst, alu_op, alu_src, branch, cond, mr, mw, size, m2r, rw, j, jr, link, ev
    function automatic logic [22:0] ctl(input logic [1:0] rd, input logic [3:0] op,
                                        input logic [1:0] src, input logic br,
                                        input logic [2:0] cond, input logic mr,
                                        input logic mw, input logic [1:0] sz,
                                        input logic m2r, input logic rw, input logic j,
                                        input logic jr, input logic lk, input logic ev);
        return {rd, op, src, br, cond, mr, mw, sz, m2r, rw, j, jr, lk, ev};
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [28:0] dut_out();
        return {bus.RegDst, bus.ALUOp, bus.ALUSrc, bus.Branch, bus.BranchCond,
                bus.MemRead, bus.MemWrite, bus.MemSize, bus.MemtoReg, bus.RegWrite,
                bus.Jump, bus.JumpReg, bus.Link, bus.ExValid, bus.Debug, bus.DebugOpcode};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic [31:0] ins, input logic idv,
                        input logic mr, input logic [4:0] ert, input logic bt,
                        input logic [22:0] ectl, input logic es, input logic ef);
        @(negedge clk);
        bus.Instruction = ins;
        bus.IdValid     = idv;
        bus.ExMemRead   = mr;
        bus.ExRt        = ert;
        bus.BranchTaken = bt;
        #1;
        check({name, ".stall"}, 32'(bus.Stall), 32'(es));
        check({name, ".flush_if"}, 32'(bus.FlushIF), 32'(ef));
        exp_q.push_back({ectl, exp_dbg, exp_dbg_op});
        name_q.push_back(name);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [28:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, ".idex"}, 32'(dut_out()), 32'(e));
            end
        end
    end

    logic [22:0] C_BUB, C_ADD, C_ADDI, C_SLTI, C_LB, C_LW, C_SH, C_SW;
    logic [22:0] C_BEQ, C_BLEZ, C_BGEZ, C_BLTZ, C_J, C_JAL, C_JR;
    logic [31:0] ADD_A, ADD_B, ADDI_A, SW_A;

    initial begin
        C_BUB  = '0;
        C_ADD  = ctl(1, 4'b0000, 0, 0, 3'd0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 1);
        C_ADDI = ctl(0, 4'b0001, 1, 0, 3'd0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 1);
        C_SLTI = ctl(0, 4'b0101, 1, 0, 3'd0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 1);
        C_LB   = ctl(0, 4'b0001, 1, 0, 3'd0, 1, 0, 2'b00, 1, 1, 0, 0, 0, 1);
        C_LW   = ctl(0, 4'b0001, 1, 0, 3'd0, 1, 0, 2'b10, 1, 1, 0, 0, 0, 1);
        C_SH   = ctl(0, 4'b0001, 1, 0, 3'd0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 1);
        C_SW   = ctl(0, 4'b0001, 1, 0, 3'd0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 1);
        C_BEQ  = ctl(0, 4'b0110, 0, 1, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        C_BLEZ = ctl(0, 4'b0110, 2, 1, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        C_BGEZ = ctl(0, 4'b0110, 2, 1, 3'b100, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        C_BLTZ = ctl(0, 4'b0110, 2, 1, 3'b101, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        C_J    = ctl(0, 4'b0000, 0, 0, 3'd0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 1);
        C_JAL  = ctl(2, 4'b0000, 0, 0, 3'd0, 0, 0, 2'b00, 0, 1, 1, 0, 1, 1);
        C_JR   = ctl(1, 4'b0000, 0, 0, 3'd0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1);

        ADD_A  = r_ins(5'd1, 5'd2, 5'd3, 6'h20);
        ADD_B  = r_ins(5'd5, 5'd7, 5'd6, 6'h20);
        ADDI_A = i_ins(6'b001000, 5'd9, 5'd5, 16'd4);
        SW_A   = i_ins(6'b101011, 5'd9, 5'd5, 16'd0);

        exp_dbg         = 1'b0;
        exp_dbg_op      = 6'd0;
        rst_n           = 1'b0;
        bus.Instruction = '0;
        bus.IdValid     = 1'b0;
        bus.ExMemRead   = 1'b0;
        bus.ExRt        = '0;
        bus.BranchTaken = 1'b0;
        #12;
        check("reset.idex", 32'(dut_out()), 32'd0);
        check("reset.stall", 32'(bus.Stall), 32'd0);
        check("reset.flush_if", 32'(bus.FlushIF), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step("add", ADD_A, 1, 0, 5'd0, 0, C_ADD, 0, 0);
        step("lu_rs_stall", ADD_B, 1, 1, 5'd5, 0, C_BUB, 1, 0);
        step("lu_release", ADD_B, 1, 0, 5'd0, 0, C_ADD, 0, 0);
        step("lu_exrt0", ADD_B, 1, 1, 5'd0, 0, C_ADD, 0, 0);
        step("lu_addi_rt", ADDI_A, 1, 1, 5'd5, 0, C_ADDI, 0, 0);
        step("lu_sw_rt", SW_A, 1, 1, 5'd5, 0, C_BUB, 1, 0);
        step("sw", SW_A, 1, 0, 5'd0, 0, C_SW, 0, 0);

        step("br_pulse", ADD_A, 1, 1, 5'd1, 1, C_BUB, 0, 1);
        step("br_second", ADD_A, 1, 1, 5'd1, 0, C_BUB, 0, 0);
        step("br_after", ADD_A, 1, 0, 5'd0, 0, C_ADD, 0, 0);

        step("jal", i_ins(6'b000011, 5'd0, 5'd0, 16'h0040), 1, 0, 5'd0, 0, C_JAL, 0, 1);
        step("after_jal", ADD_A, 1, 0, 5'd0, 0, C_ADD, 0, 0);
        step("jr", r_ins(5'd31, 5'd0, 5'd0, 6'b001000), 1, 0, 5'd0, 0, C_JR, 0, 1);
        step("j", i_ins(6'b000010, 5'd3, 5'd3, 16'h0010), 1, 1, 5'd3, 0, C_J, 0, 1);

        step("lb", i_ins(6'b100000, 5'd4, 5'd8, 16'd1), 1, 0, 5'd0, 0, C_LB, 0, 0);
        step("lw", i_ins(6'b100011, 5'd4, 5'd8, 16'd8), 1, 0, 5'd0, 0, C_LW, 0, 0);
        step("sh", i_ins(6'b101001, 5'd4, 5'd8, 16'd2), 1, 0, 5'd0, 0, C_SH, 0, 0);
        step("slti", i_ins(6'b001010, 5'd4, 5'd8, 16'hffff), 1, 0, 5'd0, 0, C_SLTI, 0, 0);
        step("beq", i_ins(6'b000100, 5'd4, 5'd8, 16'd3), 1, 0, 5'd0, 0, C_BEQ, 0, 0);
        step("blez", i_ins(6'b000110, 5'd4, 5'd0, 16'd3), 1, 0, 5'd0, 0, C_BLEZ, 0, 0);
        step("bgez", i_ins(6'b000001, 5'd4, 5'd1, 16'd3), 1, 0, 5'd0, 0, C_BGEZ, 0, 0);
        step("bltz", i_ins(6'b000001, 5'd4, 5'd0, 16'd3), 1, 0, 5'd0, 0, C_BLTZ, 0, 0);
        step("not_valid", ADD_A, 0, 0, 5'd0, 0, C_BUB, 0, 0);

        step("ill_invalid", i_ins(6'b111111, 5'd5, 5'd0, 16'd0), 0, 0, 5'd0, 0, C_BUB, 0, 0);
        step("ill_stalled", i_ins(6'b111111, 5'd5, 5'd0, 16'd0), 1, 1, 5'd5, 0, C_BUB, 1, 0);
        step("ill_branch", i_ins(6'b111111, 5'd5, 5'd0, 16'd0), 1, 0, 5'd0, 1, C_BUB, 0, 1);
        step("ill_flushcnt", i_ins(6'b111111, 5'd5, 5'd0, 16'd0), 1, 0, 5'd0, 0, C_BUB, 0, 0);
        exp_dbg    = 1'b1;
        exp_dbg_op = 6'b111111;
        step("ill_3f", i_ins(6'b111111, 5'd5, 5'd0, 16'd0), 1, 0, 5'd0, 0, C_BUB, 0, 0);
        step("ill_10", i_ins(6'b010000, 5'd5, 5'd0, 16'd0), 1, 0, 5'd0, 0, C_BUB, 0, 0);
        step("after_ill", ADD_A, 1, 0, 5'd0, 0, C_ADD, 0, 0);

        step("rebr_a", ADD_A, 1, 0, 5'd0, 1, C_BUB, 0, 1);
        step("rebr_b", ADD_A, 1, 0, 5'd0, 1, C_BUB, 0, 1);
        step("rebr_c", ADD_A, 1, 0, 5'd0, 0, C_BUB, 0, 0);
        step("rebr_d", ADD_A, 1, 0, 5'd0, 0, C_ADD, 0, 0);

        step("mid_br", ADD_A, 1, 0, 5'd0, 1, C_BUB, 0, 1);
        @(negedge clk);
        bus.BranchTaken = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_reset.idex", 32'(dut_out()), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        exp_dbg    = 1'b0;
        exp_dbg_op = 6'd0;
        step("post_reset", ADD_A, 1, 0, 5'd0, 0, C_ADD, 0, 0);
        step("idle", 32'd0, 0, 0, 5'd0, 0, C_BUB, 0, 0);

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
